steer_seq_arb: RTL and testbench
================================

// Module: steer_seq_arb
// PURPOSE
//  Clocked sequencer/arbiter that drives the dual-rail steer token into a 2-way NCL steer stage.
//  Two clocked requesters (S path, T path) share one steer; block picks one round-robin.
//  Runs a full four-phase DATA/NULL handshake on the steer rails per grant.
//  Sits on the sync/async boundary between a clocked control domain and the clockless steer.
// PARAMETERS
//  SYNC_STAGES  2    flops in the synchroniser on steer_comp (min 2)
//  TIMEOUT      255  cycles allowed per handshake phase before error (1..2^TO_W-1)
//  TO_W         8    width of phase timeout counter
//  CNT_W        8    width of per-path grant counters
// PORTS
//  clk          in   1      clock
//  initn        in   1      async active-low reset
//  req_s        in   1      S-path request, level, held until gnt_s
//  req_t        in   1      T-path request, level, held until gnt_t
//  steer        out  2      dual-rail steer token: 01=S, 10=T, 00=NULL; 11 never driven
//  steer_comp   in   1      steer completion from NCL stage (async): 1=DATA accepted, 0=NULL accepted
//  gnt_s        out  1      1-cycle pulse: S handshake fully complete (back to NULL)
//  gnt_t        out  1      1-cycle pulse: T handshake fully complete
//  busy         out  1      high in any state except IDLE/ERR
//  timeout_err  out  1      sticky; set on phase timeout, cleared only by initn
//  cnt_s        out  CNT_W  completed S grants, wraps modulo 2^CNT_W
//  cnt_t        out  CNT_W  completed T grants, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (initn=0, async): state=IDLE, steer=00, gnt_*=0, busy=0, timeout_err=0,
//   cnt_*=0, last_sel=T (so S wins first tie), sync flops=0.
//  steer_comp passes through SYNC_STAGES flops -> comp_s; FSM uses only comp_s.
//  steer is registered; changes only on a state transition, never glitches.
//  FSM:
//   IDLE: if req_s|req_t -> pick; both -> path != last_sel; one -> that one.
//         Record sel, load steer=sel rail, clear timer, -> DATA.
//   DATA: hold steer; comp_s=1 -> steer=00, clear timer, -> NULLP.
//   NULLP: hold 00; comp_s=0 -> pulse gnt_sel, cnt_sel+1, last_sel=sel, -> IDLE.
//   ERR: steer=00, busy=0, timeout_err=1; stays until initn.
//  In DATA/NULLP the timer increments each cycle; timer==TIMEOUT with comp_s not yet
//   at required level -> ERR. Checked before the advance condition is lost: if comp_s
//   arrives in the same cycle as timer==TIMEOUT, the advance wins.
//  Latency: req seen in IDLE -> steer DATA next cycle; gnt pulse = 1 cycle after comp_s
//   falls; best case per grant = 2 + 2*SYNC_STAGES cycles; no back-to-back grants
//   without one IDLE cycle.
//  Entering DATA requires comp_s=0; if comp_s=1 in IDLE, wait in IDLE (stale DATA).
//  Requests dropped while granted are ignored; handshake completes, gnt still pulses.
//  Never both gnt_s and gnt_t in one cycle; steer never 11; steer never goes directly
//   from one DATA rail to the other without passing through 00.
//  Counter wrap: 2^CNT_W-1 +1 -> 0, no flag.
//  initn asserted mid-handshake: steer drops to 00 immediately (async); NCL stage drains
//   NULL on its own.
// TESTING
//  Reset, then req_s=1 only; model steer_comp echoes steer DATA/NULL after 3 cycles
//   -> steer 01 then 00, one gnt_s pulse, cnt_s=1, cnt_t=0.
//  req_s=req_t=1 held for 4 grants -> order S,T,S,T; cnt_s=cnt_t=2; steer always via 00.
//  TIMEOUT=10, steer_comp stuck 0 -> after DATA, ERR at cycle 11 of DATA; steer=00,
//   timeout_err=1, busy=0, later requests ignored until initn.
//  steer_comp rises exactly when timer==TIMEOUT -> advance to NULLP, no error.
//  CNT_W=2, 5 S grants -> cnt_s sequence 1,2,3,0,1.
//  initn pulsed low while in DATA -> steer=00 same cycle; after release state IDLE,
//   cnt_*=0, S wins next tie.

Source files
------------

// File: rtl/steer_seq_arb.sv
`default_nettype none
// ============================================================================
// Module   : steer_seq_arb
// Brief    : Round-robin sequencer driving a dual-rail steer token through a
//            four-phase DATA/NULL handshake with a clockless NCL steer stage.
// Revision : 1.0
// ============================================================================
module steer_seq_arb #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255,
    parameter int TO_W        = 8,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             initn,
    input  logic             req_s,
    input  logic             req_t,
    output logic [1:0]       steer,
    input  logic             steer_comp,
    output logic             gnt_s,
    output logic             gnt_t,
    output logic             busy,
    output logic             timeout_err,
    output logic [CNT_W-1:0] cnt_s,
    output logic [CNT_W-1:0] cnt_t
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_NULLP = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    localparam logic [TO_W-1:0] c_timeout = TO_W'(TIMEOUT);
    localparam logic [1:0]      c_rail_s  = 2'b01;
    localparam logic [1:0]      c_rail_t  = 2'b10;

    state_t               r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                 r_sel, w_sel_nxt;        // 0 = S, 1 = T
    logic                 r_last_sel, w_last_nxt;
    logic [TO_W-1:0]      r_timer, w_timer_nxt;
    logic [1:0]           r_steer, w_steer_nxt;
    logic                 r_gnt_s, w_gnt_s_nxt;
    logic                 r_gnt_t, w_gnt_t_nxt;
    logic [CNT_W-1:0]     r_cnt_s, w_cnt_s_nxt;
    logic [CNT_W-1:0]     r_cnt_t, w_cnt_t_nxt;

    logic w_comp_s;
    logic w_req_s;
    logic w_req_t;
    logic w_pick;

    assign w_comp_s = r_sync[SYNC_STAGES-1];
    // A requester sees its grant in the same cycle, so its level is ignored for that cycle.
    assign w_req_s  = req_s & ~r_gnt_s;
    assign w_req_t  = req_t & ~r_gnt_t;
    assign w_pick   = (w_req_s && w_req_t) ? ~r_last_sel : w_req_t;

    always_ff @(posedge clk or negedge initn) begin
        if (!initn) begin
            r_sync     <= '0;
            r_state    <= ST_IDLE;
            r_sel      <= 1'b0;
            r_last_sel <= 1'b1;
            r_timer    <= '0;
            r_steer    <= 2'b00;
            r_gnt_s    <= 1'b0;
            r_gnt_t    <= 1'b0;
            r_cnt_s    <= '0;
            r_cnt_t    <= '0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], steer_comp};
            r_state    <= w_state_nxt;
            r_sel      <= w_sel_nxt;
            r_last_sel <= w_last_nxt;
            r_timer    <= w_timer_nxt;
            r_steer    <= w_steer_nxt;
            r_gnt_s    <= w_gnt_s_nxt;
            r_gnt_t    <= w_gnt_t_nxt;
            r_cnt_s    <= w_cnt_s_nxt;
            r_cnt_t    <= w_cnt_t_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_last_nxt  = r_last_sel;
        w_timer_nxt = r_timer;
        w_steer_nxt = r_steer;
        w_gnt_s_nxt = 1'b0;
        w_gnt_t_nxt = 1'b0;
        w_cnt_s_nxt = r_cnt_s;
        w_cnt_t_nxt = r_cnt_t;
        case (r_state)
            ST_IDLE: begin
                // A completion still high here is stale DATA; wait for it to clear.
                if ((w_req_s || w_req_t) && !w_comp_s) begin
                    w_sel_nxt   = w_pick;
                    w_steer_nxt = w_pick ? c_rail_t : c_rail_s;
                    w_timer_nxt = '0;
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_comp_s) begin
                    w_steer_nxt = 2'b00;
                    w_timer_nxt = '0;
                    w_state_nxt = ST_NULLP;
                end else if (r_timer == c_timeout) begin
                    w_steer_nxt = 2'b00;
                    w_state_nxt = ST_ERR;
                end else begin
                    w_timer_nxt = r_timer + TO_W'(1);
                end
            end
            ST_NULLP: begin
                if (!w_comp_s) begin
                    w_gnt_s_nxt = ~r_sel;
                    w_gnt_t_nxt = r_sel;
                    w_cnt_s_nxt = r_sel ? r_cnt_s : r_cnt_s + CNT_W'(1);
                    w_cnt_t_nxt = r_sel ? r_cnt_t + CNT_W'(1) : r_cnt_t;
                    w_last_nxt  = r_sel;
                    w_state_nxt = ST_IDLE;
                end else if (r_timer == c_timeout) begin
                    w_state_nxt = ST_ERR;
                end else begin
                    w_timer_nxt = r_timer + TO_W'(1);
                end
            end
            default: begin
                w_steer_nxt = 2'b00;
                w_state_nxt = ST_ERR;
            end
        endcase
    end

    assign steer       = r_steer;
    assign gnt_s       = r_gnt_s;
    assign gnt_t       = r_gnt_t;
    assign busy        = (r_state == ST_DATA) || (r_state == ST_NULLP);
    assign timeout_err = (r_state == ST_ERR);
    assign cnt_s       = r_cnt_s;
    assign cnt_t       = r_cnt_t;

endmodule
`default_nettype wire

// File: tb/tb_steer_seq_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_steer_seq_arb
// Brief    : Directed self-checking bench for steer_seq_arb with an NCL echo model.
// Revision : 1.0
// ============================================================================
module tb_steer_seq_arb;

    logic       clk = 1'b0;
    logic       initn;
    logic       req_s;
    logic       req_t;
    logic [1:0] steer;
    logic       steer_comp;
    logic       gnt_s;
    logic       gnt_t;
    logic       busy;
    logic       timeout_err;
    logic [1:0] cnt_s;
    logic [1:0] cnt_t;

    logic       comp_manual;
    logic       echo_en;
    logic [2:0] r_echo = 3'b000;

    int n_tests = 0;
    int n_fail  = 0;
    int n_gs    = 0;
    int n_gt    = 0;
    int n_bad   = 0;
    logic [1:0] r_prev_steer = 2'b00;
    logic       order_q[$];

    always #5 clk = ~clk;

    steer_seq_arb #(
        .SYNC_STAGES(2),
        .TIMEOUT    (10),
        .TO_W       (8),
        .CNT_W      (2)
    ) dut (
        .clk        (clk),
        .initn      (initn),
        .req_s      (req_s),
        .req_t      (req_t),
        .steer      (steer),
        .steer_comp (steer_comp),
        .gnt_s      (gnt_s),
        .gnt_t      (gnt_t),
        .busy       (busy),
        .timeout_err(timeout_err),
        .cnt_s      (cnt_s),
        .cnt_t      (cnt_t)
    );

    // NCL stage model: completion follows DATA/NULL on steer three cycles later.
    always @(posedge clk) r_echo <= {r_echo[1:0], steer != 2'b00};
    assign steer_comp = echo_en ? r_echo[2] : comp_manual;

    always @(negedge clk) begin
        if (gnt_s) begin n_gs++; order_q.push_back(1'b0); end
        if (gnt_t) begin n_gt++; order_q.push_back(1'b1); end
        if (steer == 2'b11 || (gnt_s && gnt_t) ||
            (r_prev_steer != 2'b00 && steer != 2'b00 && steer != r_prev_steer))
            n_bad++;
        r_prev_steer = steer;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        initn = 1'b0;
        req_s = 1'b0;
        req_t = 1'b0;
        repeat (2) @(negedge clk);
        initn = 1'b1;
    endtask

    task automatic wait_gnt(input int maxc, output logic got_s, output logic got_t, output logic ok);
        got_s = 1'b0;
        got_t = 1'b0;
        ok    = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (gnt_s || gnt_t) begin
                got_s = gnt_s;
                got_t = gnt_t;
                ok    = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        logic gs, gt, ok;
        int   base_s, base_t, base_q;
        logic [3:0] ord;
        int   exp_seq[5] = '{1, 2, 3, 0, 1};

        initn = 1'b0; req_s = 1'b0; req_t = 1'b0;
        comp_manual = 1'b0; echo_en = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_steer", 32'(steer), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_err", 32'(timeout_err), 32'h0);
        check("rst_cnt", 32'({cnt_s, cnt_t}), 32'h0);
        check("rst_gnt", 32'({gnt_s, gnt_t}), 32'h0);
        initn = 1'b1;

        // Single S request
        @(negedge clk);
        base_s = n_gs; base_t = n_gt;
        req_s = 1'b1;
        @(negedge clk);
        check("s_data_latency", 32'(steer), 32'h1);
        check("s_busy", 32'(busy), 32'h1);
        wait_gnt(60, gs, gt, ok);
        check("s_gnt_seen", 32'(ok), 32'h1);
        req_s = 1'b0;
        repeat (8) @(negedge clk);
        check("s_gnt_count", 32'(n_gs - base_s), 32'h1);
        check("s_no_t_gnt", 32'(n_gt - base_t), 32'h0);
        check("s_cnt_s", 32'(cnt_s), 32'h1);
        check("s_cnt_t", 32'(cnt_t), 32'h0);
        check("s_steer_null", 32'(steer), 32'h0);

        // Both requesting: round robin S,T,S,T
        do_reset();
        base_q = order_q.size();
        req_s = 1'b1; req_t = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_gnt(60, gs, gt, ok);
            check("rr_gnt_seen", 32'(ok), 32'h1);
        end
        req_s = 1'b0; req_t = 1'b0;
        repeat (8) @(negedge clk);
        ord = 4'b1111;
        if (order_q.size() >= base_q + 4)
            ord = {order_q[base_q], order_q[base_q+1], order_q[base_q+2], order_q[base_q+3]};
        check("rr_order", 32'(ord), 32'h5);
        check("rr_cnt_s", 32'(cnt_s), 32'h2);
        check("rr_cnt_t", 32'(cnt_t), 32'h2);

        // Counter wrap with 2-bit counters
        do_reset();
        req_s = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_gnt(60, gs, gt, ok);
            check("wrap_gnt_seen", 32'(ok), 32'h1);
            check("wrap_cnt_s", 32'(cnt_s), 32'(exp_seq[i]));
        end
        req_s = 1'b0;
        repeat (4) @(negedge clk);

        // Completion arriving exactly at timer==TIMEOUT advances
        do_reset();
        echo_en = 1'b0; comp_manual = 1'b0;
        @(negedge clk);
        req_s = 1'b1;
        @(posedge clk);
        #1 req_s = 1'b0;
        repeat (8) @(posedge clk);
        #1 comp_manual = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("edge_steer_null", 32'(steer), 32'h0);
        check("edge_busy", 32'(busy), 32'h1);
        check("edge_no_err", 32'(timeout_err), 32'h0);
        comp_manual = 1'b0;
        wait_gnt(40, gs, gt, ok);
        check("edge_gnt_s", 32'({ok, gs}), 32'h3);
        check("edge_cnt_s", 32'(cnt_s), 32'h1);

        // Completion stuck low: ERR after 11 DATA cycles
        do_reset();
        comp_manual = 1'b0;
        @(negedge clk);
        req_s = 1'b1;
        @(posedge clk);
        #1 req_s = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("to_c10_busy", 32'(busy), 32'h1);
        check("to_c10_err", 32'(timeout_err), 32'h0);
        check("to_c10_steer", 32'(steer), 32'h1);
        @(negedge clk);
        check("to_err", 32'(timeout_err), 32'h1);
        check("to_busy", 32'(busy), 32'h0);
        check("to_steer", 32'(steer), 32'h0);
        base_s = n_gs + n_gt;
        req_t = 1'b1;
        repeat (20) @(negedge clk);
        check("to_ignore_steer", 32'(steer), 32'h0);
        check("to_ignore_busy", 32'(busy), 32'h0);
        check("to_sticky", 32'(timeout_err), 32'h1);
        req_t = 1'b0;
        repeat (2) @(negedge clk);
        check("to_no_gnt", 32'(n_gs + n_gt - base_s), 32'h0);

        // Reset asserted mid-DATA
        do_reset();
        echo_en = 1'b1;
        req_s = 1'b1;
        wait_gnt(60, gs, gt, ok);
        req_s = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_pre_cnt_s", 32'(cnt_s), 32'h1);
        req_s = 1'b1;
        @(negedge clk);
        check("mid_in_data", 32'(steer), 32'h1);
        #2 initn = 1'b0;
        #1;
        check("mid_async_steer", 32'(steer), 32'h0);
        check("mid_async_busy", 32'(busy), 32'h0);
        check("mid_async_cnt", 32'({cnt_s, cnt_t}), 32'h0);
        @(negedge clk);
        req_s = 1'b0;
        initn = 1'b1;
        @(negedge clk);
        req_s = 1'b1; req_t = 1'b1;
        wait_gnt(80, gs, gt, ok);
        check("mid_tie_s_wins", 32'({ok, gs, gt}), 32'h6);
        req_s = 1'b0; req_t = 1'b0;
        repeat (4) @(negedge clk);

        check("steer_protocol", 32'(n_bad), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
